topview_ls_reader: RTL and testbench
====================================

TOPVIEW_LS_READER -- requirements
Module: topview_ls_reader

Parameters
REQ-001 OUT_WIDTH, default 640, topview output width; H_W = $clog2(OUT_WIDTH).
REQ-002 OUT_HEIGHT, default 480, topview output height; V_W = $clog2(OUT_HEIGHT).
REQ-003 RAM_SIZE, default 4096, segment BRAM depth; ADDR_W = $clog2(RAM_SIZE); DATA_WIDTH = 2*(V_W+H_W)+1.
REQ-004 BASE_ADDR, default RAM_SIZE-4, address of the first segment of a frame.

Interface
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock, all state.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 tv_ready  in  1  segment table complete and readable (level).
REQ-009 line_num  in  ADDR_W  number of segments written this frame.
REQ-010 raddr  out  ADDR_W  BRAM read address, registered.
REQ-011 rdata  in  DATA_WIDTH  BRAM data; valid 1 cycle after raddr is sampled.
REQ-012 m_valid  out  1  output segment valid.
REQ-013 m_ready  in  1  downstream accepts segment.
REQ-014 m_start_v, m_end_v  out  V_W each  segment endpoint rows.
REQ-015 m_start_h, m_end_h  out  H_W each  segment endpoint columns.
REQ-016 m_seg_ok  out  1  in-range flag (rdata bit 0).
REQ-017 m_last  out  1  marks final segment of frame.
REQ-018 frame_done  out  1  one-cycle pulse after last handshake.
REQ-019 aborted  out  1  one-cycle pulse on abort.
REQ-020 busy  out  1  high in any state except IDLE.

Function
REQ-021 rdata unpack, MSB first: start_v[V_W], start_h[H_W], end_v[V_W], end_h[H_W], seg_ok[1].
REQ-022 FSM states IDLE, ADDR, RDWAIT, SEND.
REQ-023 IDLE->ADDR on an edge where tv_ready=1, previous sample 0, line_num!=0; capture count=line_num, idx=0, raddr<=BASE_ADDR.
REQ-024 tv_ready rise with line_num=0: stay IDLE, no beats; frame_done pulses on the next cycle.
REQ-025 ADDR->RDWAIT unconditionally; RDWAIT->SEND registers unpacked rdata into outputs and sets m_valid=1.
REQ-026 First m_valid high 2 edges after the trigger edge; beat-to-beat minimum 3 cycles.
REQ-027 SEND: hold m_valid and all data stable until m_valid&&m_ready.
REQ-028 Handshake with idx!=count-1: m_valid<=0, idx++, raddr<=raddr+1 mod RAM_SIZE, ->ADDR.
REQ-029 Handshake with idx==count-1: m_valid<=0, ->IDLE, frame_done pulses on the following cycle.
REQ-030 m_last=1 exactly while m_valid is high for idx==count-1.
REQ-031 raddr wraps RAM_SIZE-1 -> 0 with no gap.
REQ-032 tv_ready=0 in ADDR/RDWAIT/SEND: abort; m_valid<=0 same edge; ->IDLE; aborted pulses 1 cycle; no frame_done.
REQ-033 A new frame starts only from IDLE, on a fresh tv_ready rising edge; tv_ready held high after a frame does not restart.
REQ-034 line_num changes after capture are ignored.
REQ-035 m_seg_ok=0 segments are still presented, with m_seg_ok=0.

Reset
REQ-036 rst=1: state IDLE; raddr=BASE_ADDR; m_valid, m_last, frame_done, aborted, busy = 0; data outputs = 0; previous tv_ready sample = 0.
REQ-037 rst mid-frame discards the frame; no pulses.
REQ-038 With tv_ready already 1 at reset release, the first sample counts as a rising edge.

Verification
REQ-039 line_num=3, m_ready=1: raddr 4092,4093,4094; 3 beats; m_last on beat 3; frame_done 1 cycle after.
REQ-040 line_num=6, BASE_ADDR=4092: raddr 4092..4095,0,1; data matches BRAM contents.
REQ-041 m_ready low 5 cycles during beat 2: m_valid and data stable; no raddr change until handshake.
REQ-042 tv_ready drops during SEND of beat 2 of 4: m_valid falls next edge; aborted 1 pulse; no frame_done; next rise restarts at BASE_ADDR.
REQ-043 rdata=all-ones, OUT 640x480: start_v=511, start_h=1023, end_v=511, end_h=1023, seg_ok=1.
REQ-044 line_num=0 at rise: no m_valid; frame_done 1 pulse; rst asserted mid-frame: all outputs 0 next cycle.

Source files
------------

// File: rtl/topview_ls_reader_if.sv
// Segment output bus of the topview line-segment reader.
// Master drives segment beats, slave returns m_ready.
interface topview_ls_reader_if #(
  parameter int V_W = 9,
  parameter int H_W = 10
);
  logic           m_valid;
  logic           m_ready;
  logic [V_W-1:0] m_start_v;
  logic [H_W-1:0] m_start_h;
  logic [V_W-1:0] m_end_v;
  logic [H_W-1:0] m_end_h;
  logic           m_seg_ok;
  logic           m_last;

  modport master (
    output m_valid,
    output m_start_v,
    output m_start_h,
    output m_end_v,
    output m_end_h,
    output m_seg_ok,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_start_v,
    input  m_start_h,
    input  m_end_v,
    input  m_end_h,
    input  m_seg_ok,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/topview_ls_reader.sv
// Walks the frame's segment table in BRAM and streams one
// unpacked segment per valid/ready beat.
module topview_ls_reader #(
  parameter  int OUT_WIDTH  = 640,
  parameter  int OUT_HEIGHT = 480,
  parameter  int RAM_SIZE   = 4096,
  parameter  int BASE_ADDR  = RAM_SIZE - 4,
  localparam int H_W        = $clog2(OUT_WIDTH),
  localparam int V_W        = $clog2(OUT_HEIGHT),
  localparam int ADDR_W     = $clog2(RAM_SIZE),
  localparam int DATA_WIDTH = 2 * (V_W + H_W) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tv_ready,
  input  logic [ADDR_W-1:0]     line_num,
  output logic [ADDR_W-1:0]     raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  topview_ls_reader_if.master   m,
  output logic                  frame_done,
  output logic                  aborted,
  output logic                  busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ADDR   = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;
  localparam logic [1:0] SEND   = 2'd3;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(RAM_SIZE - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic              tv_prev_q, tv_prev_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic [V_W-1:0]    sv_q, sv_d;
  logic [H_W-1:0]    sh_q, sh_d;
  logic [V_W-1:0]    ev_q, ev_d;
  logic [H_W-1:0]    eh_q, eh_d;
  logic              ok_q, ok_d;

  logic              tv_rise;
  logic              last_idx;
  logic [ADDR_W-1:0] raddr_nxt;

  assign tv_rise   = tv_ready && !tv_prev_q;
  assign last_idx  = (idx_q == count_q - ONE);
  assign raddr_nxt = (raddr_q == TOP) ? '0 : raddr_q + ONE;

  always_comb begin
    state_d   = state_q;
    tv_prev_d = tv_ready;
    count_d   = count_q;
    idx_d     = idx_q;
    raddr_d   = raddr_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    sv_d      = sv_q;
    sh_d      = sh_q;
    ev_d      = ev_q;
    eh_d      = eh_q;
    ok_d      = ok_q;

    unique case (state_q)
      IDLE: begin
        if (tv_rise) begin
          if (line_num != '0) begin
            state_d = ADDR;
            count_d = line_num;
            idx_d   = '0;
            raddr_d = BASE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ADDR: begin
        state_d = RDWAIT;
      end
      RDWAIT: begin
        state_d = SEND;
        valid_d = 1'b1;
        last_d  = last_idx;
        sv_d    = rdata[2*V_W+2*H_W : V_W+2*H_W+1];
        sh_d    = rdata[V_W+2*H_W : V_W+H_W+1];
        ev_d    = rdata[V_W+H_W : H_W+1];
        eh_d    = rdata[H_W:1];
        ok_d    = rdata[0];
      end
      SEND: begin
        if (valid_q && m.m_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_idx) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ADDR;
            idx_d   = idx_q + ONE;
            raddr_d = raddr_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Losing tv_ready mid-frame overrides any pending handshake.
    if (state_q != IDLE && !tv_ready) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b0;
      abort_d = 1'b1;
      idx_d   = idx_q;
      raddr_d = raddr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tv_prev_q <= 1'b0;
      count_q   <= '0;
      idx_q     <= '0;
      raddr_q   <= BASE;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      sv_q      <= '0;
      sh_q      <= '0;
      ev_q      <= '0;
      eh_q      <= '0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tv_prev_q <= tv_prev_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      raddr_q   <= raddr_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      sv_q      <= sv_d;
      sh_q      <= sh_d;
      ev_q      <= ev_d;
      eh_q      <= eh_d;
      ok_q      <= ok_d;
    end
  end

  assign raddr       = raddr_q;
  assign m.m_valid   = valid_q;
  assign m.m_last    = last_q;
  assign m.m_start_v = sv_q;
  assign m.m_start_h = sh_q;
  assign m.m_end_v   = ev_q;
  assign m.m_end_h   = eh_q;
  assign m.m_seg_ok  = ok_q;
  assign frame_done  = done_q;
  assign aborted     = abort_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_topview_ls_reader.sv
// Directed bench for topview_ls_reader with a synchronous
// BRAM model holding a per-address field pattern.
module tb_topview_ls_reader;

  localparam int OW = 640;
  localparam int OH = 480;
  localparam int RS = 4096;
  localparam int VW = $clog2(OH);
  localparam int HW = $clog2(OW);
  localparam int AW = $clog2(RS);
  localparam int DW = 2 * (VW + HW) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          tv_ready;
  logic [AW-1:0] line_num;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          frame_done;
  logic          aborted;
  logic          busy;

  logic [DW-1:0] mem [RS];

  int nvec = 0;
  int nerr = 0;

  topview_ls_reader_if #(.V_W(VW), .H_W(HW)) m_if ();

  topview_ls_reader #(
    .OUT_WIDTH (OW),
    .OUT_HEIGHT(OH),
    .RAM_SIZE  (RS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tv_ready  (tv_ready),
    .line_num  (line_num),
    .raddr     (raddr),
    .rdata     (rdata),
    .m         (m_if),
    .frame_done(frame_done),
    .aborted   (aborted),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[raddr];

  function automatic logic [VW-1:0] fsv(int a);
    return VW'(a * 3);
  endfunction
  function automatic logic [HW-1:0] fsh(int a);
    return HW'(a * 7);
  endfunction
  function automatic logic [VW-1:0] fev(int a);
    return VW'(a + 5);
  endfunction
  function automatic logic [HW-1:0] feh(int a);
    return HW'(a ^ 341);
  endfunction
  function automatic logic fok(int a);
    return a[0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!m_if.m_valid && cnt < 10);
  endtask

  task automatic frame(input int n, input int a0,
                       input int stall_k, input int stall_n);
    int cnt;
    int a;
    a = a0;
    for (int k = 0; k < n; k++) begin
      wait_valid(cnt);
      line_num = AW'(1);
      chk("latency", 64'(cnt), 64'd3);
      if (!m_if.m_valid) return;
      if (k == stall_k) begin
        m_if.m_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          chk("stall_valid", 64'(m_if.m_valid), 64'd1);
          chk("stall_sv", 64'(m_if.m_start_v), 64'(fsv(a)));
          chk("stall_eh", 64'(m_if.m_end_h), 64'(feh(a)));
          chk("stall_raddr", 64'(raddr), 64'(a));
        end
        m_if.m_ready = 1'b1;
      end
      chk("raddr", 64'(raddr), 64'(a));
      chk("start_v", 64'(m_if.m_start_v), 64'(fsv(a)));
      chk("start_h", 64'(m_if.m_start_h), 64'(fsh(a)));
      chk("end_v", 64'(m_if.m_end_v), 64'(fev(a)));
      chk("end_h", 64'(m_if.m_end_h), 64'(feh(a)));
      chk("seg_ok", 64'(m_if.m_seg_ok), 64'(fok(a)));
      chk("last", 64'(m_if.m_last), 64'(k == n - 1));
      chk("fd_early", 64'(frame_done), 64'd0);
      a = (a + 1) % RS;
    end
    @(negedge clk);
    chk("frame_done", 64'(frame_done), 64'd1);
    chk("valid_end", 64'(m_if.m_valid), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    @(negedge clk);
    chk("fd_pulse", 64'(frame_done), 64'd0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < RS; i++)
      mem[i] = {fsv(i), fsh(i), fev(i), feh(i), fok(i)};
    rst = 1'b1;
    tv_ready = 1'b0;
    line_num = '0;
    m_if.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_raddr", 64'(raddr), 64'd4092);
    chk("rst_valid", 64'(m_if.m_valid), 64'd0);
    chk("rst_last", 64'(m_if.m_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fd", 64'(frame_done), 64'd0);
    chk("rst_ab", 64'(aborted), 64'd0);
    chk("rst_sv", 64'(m_if.m_start_v), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    line_num = AW'(3);
    tv_ready = 1'b1;
    m_if.m_ready = 1'b1;
    frame(3, 4092, -1, 0);

    repeat (4) begin
      @(negedge clk);
      chk("hold_valid", 64'(m_if.m_valid), 64'd0);
      chk("hold_busy", 64'(busy), 64'd0);
    end

    tv_ready = 1'b0;
    @(negedge clk);
    line_num = AW'(6);
    tv_ready = 1'b1;
    frame(6, 4092, 1, 5);

    tv_ready = 1'b0;
    @(negedge clk);
    line_num = AW'(4);
    tv_ready = 1'b1;
    wait_valid(cnt);
    chk("ab_lat", 64'(cnt), 64'd3);
    @(negedge clk);
    m_if.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("ab_valid2", 64'(m_if.m_valid), 64'd1);
    chk("ab_raddr2", 64'(raddr), 64'd4093);
    tv_ready = 1'b0;
    @(negedge clk);
    chk("ab_valid", 64'(m_if.m_valid), 64'd0);
    chk("ab_pulse", 64'(aborted), 64'd1);
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_fd", 64'(frame_done), 64'd0);
    @(negedge clk);
    chk("ab_pulse_end", 64'(aborted), 64'd0);
    chk("ab_fd2", 64'(frame_done), 64'd0);
    m_if.m_ready = 1'b1;
    line_num = AW'(2);
    tv_ready = 1'b1;
    frame(2, 4092, -1, 0);

    tv_ready = 1'b0;
    mem[4092] = '1;
    @(negedge clk);
    line_num = AW'(1);
    tv_ready = 1'b1;
    wait_valid(cnt);
    chk("ones_lat", 64'(cnt), 64'd3);
    chk("ones_sv", 64'(m_if.m_start_v), 64'd511);
    chk("ones_sh", 64'(m_if.m_start_h), 64'd1023);
    chk("ones_ev", 64'(m_if.m_end_v), 64'd511);
    chk("ones_eh", 64'(m_if.m_end_h), 64'd1023);
    chk("ones_ok", 64'(m_if.m_seg_ok), 64'd1);
    chk("ones_last", 64'(m_if.m_last), 64'd1);
    mem[4092] = {fsv(4092), fsh(4092), fev(4092), feh(4092), fok(4092)};
    repeat (3) @(negedge clk);

    tv_ready = 1'b0;
    @(negedge clk);
    line_num = '0;
    tv_ready = 1'b1;
    @(negedge clk);
    chk("zero_fd", 64'(frame_done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("zero_fd_end", 64'(frame_done), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("zero_valid", 64'(m_if.m_valid), 64'd0);
    end

    tv_ready = 1'b0;
    @(negedge clk);
    line_num = AW'(3);
    tv_ready = 1'b1;
    wait_valid(cnt);
    chk("rst_mid_lat", 64'(cnt), 64'd3);
    m_if.m_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rm_valid", 64'(m_if.m_valid), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_last", 64'(m_if.m_last), 64'd0);
    chk("rm_sv", 64'(m_if.m_start_v), 64'd0);
    chk("rm_eh", 64'(m_if.m_end_h), 64'd0);
    chk("rm_raddr", 64'(raddr), 64'd4092);
    chk("rm_fd", 64'(frame_done), 64'd0);
    chk("rm_ab", 64'(aborted), 64'd0);
    @(negedge clk);
    line_num = AW'(2);
    m_if.m_ready = 1'b1;
    rst = 1'b0;
    frame(2, 4092, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
